// File: rtl/tsu_ts_queue_arb.sv
// Timestamp event queue: one holding register per direction (rx/tx), round-robin
// arbitration into a shared show-ahead FIFO, with drop counters and level interrupt.
module tsu_ts_queue_arb #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned INT_THRESH = 1
) (
  input  logic                   rtc_clk,
  input  logic                   rtc_rst_n,
  input  logic                   enable_i,
  input  logic                   rx_stb_i,
  input  logic [79:0]            rx_ts_i,
  input  logic [15:0]            rx_seqid_i,
  input  logic [3:0]             rx_msgtype_i,
  input  logic                   tx_stb_i,
  input  logic [79:0]            tx_ts_i,
  input  logic [15:0]            tx_seqid_i,
  input  logic [3:0]             tx_msgtype_i,
  input  logic                   pop_i,
  output logic                   q_valid_o,
  output logic                   q_dir_o,
  output logic [79:0]            q_ts_o,
  output logic [15:0]            q_seqid_o,
  output logic [3:0]             q_msgtype_o,
  output logic [$clog2(DEPTH):0] q_level_o,
  output logic [7:0]             rx_drop_cnt_o,
  output logic [7:0]             tx_drop_cnt_o,
  input  logic                   clr_cnt_i,
  output logic                   int_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = 100;
  localparam logic [AW:0] Full = (AW+1)'(DEPTH);

  logic [AW:0]   level_q, level_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          rx_vld_q, rx_vld_d, tx_vld_q, tx_vld_d;
  logic [DW-1:0] rx_desc_q, rx_desc_d, tx_desc_q, tx_desc_d;
  logic          rr_last_q, rr_last_d;
  logic [7:0]    rx_drop_q, rx_drop_d, tx_drop_q, tx_drop_d;
  logic          int_q, int_d;
  logic [DW:0]   mem_q [DEPTH];

  logic          pop_eff, space, gnt_rx, gnt_tx, gnt, rx_drop, tx_drop;
  logic [DW:0]   wdata;

  always_comb begin
    pop_eff = enable_i & pop_i & (level_q != '0);
    // A same-cycle pop frees a slot for the grant.
    space   = (level_q != Full) | pop_eff;
    // rr_last_q: 0 = rx granted last, 1 = tx granted last.
    gnt_rx  = enable_i & space & rx_vld_q & (~tx_vld_q | rr_last_q);
    gnt_tx  = enable_i & space & tx_vld_q & (~rx_vld_q | ~rr_last_q);
    gnt     = gnt_rx | gnt_tx;
    wdata   = gnt_tx ? {1'b1, tx_desc_q} : {1'b0, rx_desc_q};
    rx_drop = enable_i & rx_stb_i & rx_vld_q & ~gnt_rx;
    tx_drop = enable_i & tx_stb_i & tx_vld_q & ~gnt_tx;
  end

  always_comb begin
    rx_vld_d  = rx_vld_q;
    rx_desc_d = rx_desc_q;
    tx_vld_d  = tx_vld_q;
    tx_desc_d = tx_desc_q;
    if (!enable_i) begin
      rx_vld_d = 1'b0;
      tx_vld_d = 1'b0;
    end else begin
      if (rx_stb_i && (!rx_vld_q || gnt_rx)) begin
        rx_vld_d  = 1'b1;
        rx_desc_d = {rx_ts_i, rx_seqid_i, rx_msgtype_i};
      end else if (gnt_rx) begin
        rx_vld_d = 1'b0;
      end
      if (tx_stb_i && (!tx_vld_q || gnt_tx)) begin
        tx_vld_d  = 1'b1;
        tx_desc_d = {tx_ts_i, tx_seqid_i, tx_msgtype_i};
      end else if (gnt_tx) begin
        tx_vld_d = 1'b0;
      end
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rr_last_d = rr_last_q;
    if (!enable_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      rr_last_d = 1'b1;
    end else begin
      if (gnt)     wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_eff) rd_ptr_d = rd_ptr_q + AW'(1);
      if (gnt)     rr_last_d = gnt_tx;
      unique case ({gnt, pop_eff})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
    int_d = enable_i & (32'(level_q) >= INT_THRESH);
  end

  always_comb begin
    rx_drop_d = rx_drop_q;
    tx_drop_d = tx_drop_q;
    if (clr_cnt_i) begin
      rx_drop_d = '0;
      tx_drop_d = '0;
    end else begin
      if (rx_drop && rx_drop_q != 8'hFF) rx_drop_d = rx_drop_q + 8'd1;
      if (tx_drop && tx_drop_q != 8'hFF) tx_drop_d = tx_drop_q + 8'd1;
    end
  end

  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rx_vld_q  <= 1'b0;
      tx_vld_q  <= 1'b0;
      rx_desc_q <= '0;
      tx_desc_q <= '0;
      rr_last_q <= 1'b1;
      rx_drop_q <= '0;
      tx_drop_q <= '0;
      int_q     <= 1'b0;
    end else begin
      level_q   <= level_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rx_vld_q  <= rx_vld_d;
      tx_vld_q  <= tx_vld_d;
      rx_desc_q <= rx_desc_d;
      tx_desc_q <= tx_desc_d;
      rr_last_q <= rr_last_d;
      rx_drop_q <= rx_drop_d;
      tx_drop_q <= tx_drop_d;
      int_q     <= int_d;
    end
  end

  // Queue storage is intentionally left unreset.
  always_ff @(posedge rtc_clk) begin
    if (gnt) mem_q[wr_ptr_q] <= wdata;
  end

  assign q_valid_o     = (level_q != '0);
  assign {q_dir_o, q_ts_o, q_seqid_o, q_msgtype_o} = mem_q[rd_ptr_q];
  assign q_level_o     = level_q;
  assign rx_drop_cnt_o = rx_drop_q;
  assign tx_drop_cnt_o = tx_drop_q;
  assign int_o         = int_q & enable_i;

endmodule
